// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the unified memory port arbiter.
// The master modport is the arbiter's view; slave is the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BW = DW / 8;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [BW-1:0] ls_be;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          stall_o;
  logic          err_o;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_o, err_o
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction
// in flight, with a bounded LS burst so fetch cannot starve, and a no-ack timeout abort.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_LS_BURST = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = $clog2(MAX_LS_BURST + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic          owner_ls;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } txn_t;

  state_t        state_q, state_d;
  txn_t          txn_q, txn_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic          err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;
  logic          if_gnt_c, ls_gnt_c;

  // State and registered outputs; reset drops any in-flight transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      timer_q     <= '0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      timer_q     <= timer_d;
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Arbitration, transaction latch, completion and timeout.
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    timer_d     = timer_q;
    streak_d    = streak_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt_c    = 1'b0;
    ls_gnt_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!bus.if_req) streak_d = '0;
        if (bus.ls_req && (!bus.if_req || (streak_q < SW'(MAX_LS_BURST)))) begin
          ls_gnt_c       = 1'b1;
          txn_d.owner_ls = 1'b1;
          txn_d.we       = bus.ls_we;
          txn_d.addr     = bus.ls_addr;
          txn_d.wdata    = bus.ls_wdata;
          txn_d.be       = bus.ls_we ? bus.ls_be : '1;
          state_d        = BUSY;
          if (bus.if_req && (streak_q != SW'(MAX_LS_BURST))) streak_d = streak_q + SW'(1);
        end else if (bus.if_req) begin
          if_gnt_c       = 1'b1;
          txn_d.owner_ls = 1'b0;
          txn_d.we       = 1'b0;
          txn_d.addr     = bus.if_addr;
          txn_d.wdata    = '0;
          txn_d.be       = '1;
          streak_d       = '0;
          state_d        = BUSY;
        end
      end
      BUSY: begin
        // An ack landing on the timeout cycle still completes normally.
        if (bus.mem_ack) begin
          state_d = IDLE;
          if (txn_q.owner_ls) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = txn_q.we ? '0 : bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          if (txn_q.owner_ls) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = '0;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = '0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.ls_gnt    = ls_gnt_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = (state_q == BUSY) & txn_q.we;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_wdata = txn_q.wdata;
  assign bus.mem_be    = txn_q.be;
  assign bus.stall_o   = bus.if_req & ~if_rvalid_q;
  assign bus.err_o     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions into a
// scoreboard queue, a monitor pops and compares on every rvalid pulse.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_LS_BURST(4), .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          ack_lat = 1;
  logic        force_ack = 1'b0;
  logic [31:0] rd_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic is_ls, input logic [31:0] d, input logic e);
    exp_t x;
    x.is_ls = is_ls;
    x.data  = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Number of consecutive cycles mem_req stays high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.mem_req && n < 400) begin
      step();
      n++;
    end
  endtask

  // Memory model: acks on the ack_lat-th cycle of mem_req (0 = never); force_ack acks regardless.
  initial begin : responder
    int busy_cnt;
    busy_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) busy_cnt++;
      else busy_cnt = 0;
      bus.mem_ack   = force_ack | (bus.mem_req && ack_lat != 0 && busy_cnt == ack_lat);
      bus.mem_rdata = rd_data;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.if_rvalid || bus.ls_rvalid) begin
        check("rvalid_exclusive", 32'(bus.if_rvalid & bus.ls_rvalid), 0);
        if (sb.size() == 0) begin
          check("unexpected_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 0);
        end else begin
          e = sb.pop_front();
          check("rvalid_owner", 32'(bus.ls_rvalid), 32'(e.is_ls));
          check("rdata", e.is_ls ? bus.ls_rdata : bus.if_rdata, e.data);
          check("err_o", 32'(bus.err_o), 32'(e.err));
        end
      end else if (bus.err_o) begin
        check("err_without_rvalid", 32'(bus.err_o), 0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic exp_order [6];
    int   n;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0; bus.ls_be = 4'h0;

    // Reset state
    #3;
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 0);
    check("rst_ls_rvalid", 32'(bus.ls_rvalid), 0);
    check("rst_err_o", 32'(bus.err_o), 0);
    check("rst_stall_o", 32'(bus.stall_o), 0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b1;
    step();

    // 1: fetch with 1-cycle memory, then a back-to-back fetch in the rvalid cycle
    rd_data = 32'h00500093; bus.if_req = 1'b1; bus.if_addr = 32'h40; #1;
    check("t1_if_gnt", 32'(bus.if_gnt), 1);
    check("t1_stall_pending", 32'(bus.stall_o), 1);
    push(1'b0, 32'h00500093, 1'b0);
    step(); bus.if_req = 1'b0;
    check("t1_mem_req", 32'(bus.mem_req), 1);
    check("t1_mem_addr", bus.mem_addr, 32'h40);
    check("t1_mem_we", 32'(bus.mem_we), 0);
    check("t1_mem_be", 32'(bus.mem_be), 32'hF);
    step();
    check("t1_if_rvalid", 32'(bus.if_rvalid), 1);
    rd_data = 32'h00A00113; bus.if_req = 1'b1; bus.if_addr = 32'h44; #1;
    check("t1_gnt_in_rvalid_cycle", 32'(bus.if_gnt), 1);
    check("t1_stall_on_rvalid", 32'(bus.stall_o), 0);
    push(1'b0, 32'h00A00113, 1'b0);
    step(); bus.if_req = 1'b0;
    check("t1_mem_addr2", bus.mem_addr, 32'h44);
    check("t1_no_rvalid_busy", 32'(bus.if_rvalid), 0);
    step();
    check("t1_if_rvalid2", 32'(bus.if_rvalid), 1);
    step();
    check("t1_rdata_hold", bus.if_rdata, 32'h00A00113);
    check("t1_stall_low", 32'(bus.stall_o), 0);

    // 2: store with 3-cycle memory, then a load whose mem_be must be all-ones
    ack_lat = 3; rd_data = 32'h12345678;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h100; bus.ls_wdata = 32'hDEADBEEF; bus.ls_be = 4'b0011; #1;
    check("t2_ls_gnt", 32'(bus.ls_gnt), 1);
    check("t2_if_gnt", 32'(bus.if_gnt), 0);
    push(1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) bus.ls_req = 1'b0;
      check("t2_mem_req", 32'(bus.mem_req), 1);
      check("t2_mem_we", 32'(bus.mem_we), 1);
      check("t2_mem_be", 32'(bus.mem_be), 3);
    end
    check("t2_mem_addr", bus.mem_addr, 32'h100);
    check("t2_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step();
    check("t2_mem_req_drop", 32'(bus.mem_req), 0);
    check("t2_ls_rvalid", 32'(bus.ls_rvalid), 1);
    ack_lat = 1; rd_data = 32'h11223344;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h104; #1;
    check("t2_load_gnt", 32'(bus.ls_gnt), 1);
    push(1'b1, 32'h11223344, 1'b0);
    step(); bus.ls_req = 1'b0;
    check("t2_load_be", 32'(bus.mem_be), 32'hF);
    check("t2_load_we", 32'(bus.mem_we), 0);
    step(); step();

    // 3: both requesters held high -> LS,LS,LS,LS,IF,LS
    rd_data = 32'hCAFE0001;
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h300; bus.ls_be = 4'hF;
    for (int g = 0; g < 6; g++) begin
      int t;
      t = 0;
      #1;
      while (!(bus.if_gnt || bus.ls_gnt) && t < 8) begin
        step();
        t++;
      end
      check("t3_gnt_seen", 32'(t < 8), 1);
      check("t3_gnt_exclusive", 32'(bus.if_gnt & bus.ls_gnt), 0);
      check("t3_grant_order", 32'(bus.ls_gnt), 32'(exp_order[g]));
      push(exp_order[g], 32'hCAFE0001, 1'b0);
      step();
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    step(); step();

    // 4: memory never acks -> abort after 255 BUSY cycles, then a normal fetch
    ack_lat = 0; rd_data = 32'h55555555;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h400; #1;
    check("t4_ls_gnt", 32'(bus.ls_gnt), 1);
    push(1'b1, 32'h0, 1'b1);
    step(); bus.ls_req = 1'b0;
    count_busy(n);
    check("t4_busy_cycles", 32'(n), 255);
    check("t4_err_o", 32'(bus.err_o), 1);
    check("t4_ls_rvalid", 32'(bus.ls_rvalid), 1);
    check("t4_if_rdata_hold", bus.if_rdata, 32'hCAFE0001);
    ack_lat = 1; rd_data = 32'h00000013;
    bus.if_req = 1'b1; bus.if_addr = 32'h44; #1;
    check("t4_next_gnt", 32'(bus.if_gnt), 1);
    push(1'b0, 32'h00000013, 1'b0);
    step(); bus.if_req = 1'b0;
    step();
    check("t4_err_cleared", 32'(bus.err_o), 0);
    step();

    // 6: ack coincident with the timeout cycle, then spurious acks in IDLE
    ack_lat = 255; rd_data = 32'h0BADF00D;
    bus.if_req = 1'b1; bus.if_addr = 32'h48; #1;
    check("t6_if_gnt", 32'(bus.if_gnt), 1);
    push(1'b0, 32'h0BADF00D, 1'b0);
    step(); bus.if_req = 1'b0;
    count_busy(n);
    check("t6_busy_cycles", 32'(n), 255);
    check("t6_if_rvalid", 32'(bus.if_rvalid), 1);
    check("t6_no_err", 32'(bus.err_o), 0);
    ack_lat = 1; force_ack = 1'b1;
    step(); step();
    force_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_idle_ack_ignored", {29'b0, bus.if_rvalid, bus.ls_rvalid, bus.err_o}, 0);
    end

    // 5: asynchronous reset in the middle of a BUSY transaction
    ack_lat = 0; rd_data = 32'h77777777;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h500; #1;
    check("t5_ls_gnt", 32'(bus.ls_gnt), 1);
    step(); bus.ls_req = 1'b0;
    step(); step();
    check("t5_busy_before_rst", 32'(bus.mem_req), 1);
    #1 rst = 1'b0;
    #1;
    check("t5_mem_req_async", 32'(bus.mem_req), 0);
    check("t5_mem_addr", bus.mem_addr, 0);
    check("t5_ls_rdata", bus.ls_rdata, 0);
    check("t5_if_rdata", bus.if_rdata, 0);
    check("t5_err_o", 32'(bus.err_o), 0);
    step(); step();
    rst = 1'b1;
    step(); step(); step();
    check("t5_no_rvalid_after_rst", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 0);
    ack_lat = 1; rd_data = 32'h00100073;
    bus.if_req = 1'b1; bus.if_addr = 32'h50; #1;
    check("t5_post_rst_gnt", 32'(bus.if_gnt), 1);
    push(1'b0, 32'h00100073, 1'b0);
    step(); bus.if_req = 1'b0;
    check("t5_post_rst_addr", bus.mem_addr, 32'h50);
    step();
    check("t5_post_rst_rvalid", 32'(bus.if_rvalid), 1);
    step(); step();

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
